// File: rtl/msk_rnd_pkg.sv
// Shared types and constants for the masked-gadget randomness feeder.
// Holds the LFSR geometry, tap positions and the feeder FSM state type.
package msk_rnd_pkg;

  localparam int LFSR_W       = 64;
  localparam int SEED_CHUNK_W = 32;
  localparam int TAP0         = 63;
  localparam int TAP1         = 62;
  localparam int TAP2         = 60;
  localparam int TAP3         = 59;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } fsm_t;

  // Feedback of x^64+x^63+x^61+x^60+1 in Fibonacci form
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
  endfunction

endpackage

// File: rtl/msk_lfsr_step.sv
// Combinational N-step advance of the 64-bit Fibonacci LFSR (unrolled).
module msk_lfsr_step
  import msk_rnd_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  logic [LFSR_W-1:0] t;

  always_comb begin
    t = cur;
    for (int i = 0; i < N; i++) begin
      t = {t[LFSR_W-2:0], lfsr_fb(t)};
    end
    nxt = t;
  end

endmodule

// File: rtl/msk_rnd_feeder.sv
// Fresh-randomness feeder for HPC2 masked gadgets: seedable LFSR, warm-up, valid/ready out.
// Optional macro MSK_RND_FEEDER_ZERO_EN forces rnd to zero (debug only, never for SCA builds).
module msk_rnd_feeder
  import msk_rnd_pkg::*;
#(
  parameter int d      = 2,
  parameter int RND_W  = d * (d - 1) / 2,
  parameter int WARMUP = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEED_CHUNK_W-1:0] seed_in,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic                    reseed_req,
  output logic [RND_W-1:0]        rnd,
  output logic                    rnd_valid,
  input  logic                    rnd_ready,
  output logic                    seed_zero
);

  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  fsm_t              state, state_nxt;
  logic [LFSR_W-1:0] s, s_nxt, s_adv;
  logic              chunk_cnt, chunk_nxt;
  logic [WCNT_W-1:0] warm_cnt, warm_nxt;
  logic              zero_nxt;

  msk_lfsr_step #(.N(RND_W)) u_step (
    .cur (s),
    .nxt (s_adv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEED;
      s         <= '0;
      chunk_cnt <= 1'b0;
      warm_cnt  <= '0;
      seed_zero <= 1'b0;
    end else begin
      state     <= state_nxt;
      s         <= s_nxt;
      chunk_cnt <= chunk_nxt;
      warm_cnt  <= warm_nxt;
      seed_zero <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_nxt      = s;
    chunk_nxt  = chunk_cnt;
    warm_nxt   = warm_cnt;
    zero_nxt   = 1'b0;
    seed_ready = (state == SEED);
    rnd_valid  = (state == RUN);
    case (state)
      SEED: begin
        if (seed_valid) begin
          s_nxt     = {s[SEED_CHUNK_W-1:0], seed_in};
          chunk_nxt = ~chunk_cnt;
          if (chunk_cnt) begin
            // An all-zero state would lock the LFSR; substitute 1 and flag it
            if (s_nxt == '0) begin
              s_nxt    = LFSR_W'(1);
              zero_nxt = 1'b1;
            end
            warm_nxt  = '0;
            state_nxt = (WARMUP == 0) ? RUN : WARM;
          end
        end
      end
      WARM: begin
        s_nxt    = s_adv;
        warm_nxt = WCNT_W'(warm_cnt + 1'b1);
        if (warm_cnt == WARM_LAST) state_nxt = RUN;
      end
      RUN: begin
        // Reseed wins over a same-cycle transfer: the state is held
        if (reseed_req) begin
          state_nxt = SEED;
          chunk_nxt = 1'b0;
        end else if (rnd_ready) begin
          s_nxt = s_adv;
        end
      end
      default: state_nxt = SEED;
    endcase
  end

`ifdef MSK_RND_FEEDER_ZERO_EN
  assign rnd = '0;
`else
  always_comb begin
    rnd = '0;
    for (int k = 0; k < RND_W; k++) rnd[k] = s[LFSR_W-1-k];
  end
`endif

endmodule

// File: tb/tb_msk_rnd_feeder.sv
// Self-checking bench for msk_rnd_feeder: randomized traffic against a bit-stream model.
module tb_msk_rnd_feeder;

  localparam int TB_D      = 3;
  localparam int TB_RND_W  = 3;
  localparam int TB_WARMUP = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [31:0]          seed_in = '0;
  logic                 seed_valid = 1'b0;
  logic                 seed_ready;
  logic                 reseed_req = 1'b0;
  logic [TB_RND_W-1:0]  rnd;
  logic                 rnd_valid;
  logic                 rnd_ready = 1'b0;
  logic                 seed_zero;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of the next 64 output bits; o[n+64] = o[n]^o[n+1]^o[n+3]^o[n+4]
  bit mq[$];

  msk_rnd_feeder #(.d(TB_D), .RND_W(TB_RND_W), .WARMUP(TB_WARMUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .reseed_req (reseed_req),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .seed_zero  (seed_zero)
  );

  always #5 clk = ~clk;

  function automatic void model_load(input logic [63:0] v);
    logic [63:0] x;
    x = (v == 64'h0) ? 64'h1 : v;
    mq.delete();
    for (int j = 63; j >= 0; j--) mq.push_back(x[j]);
  endfunction

  function automatic void model_consume(input int nbits);
    bit nb;
    for (int i = 0; i < nbits; i++) begin
      nb = mq[0] ^ mq[1] ^ mq[3] ^ mq[4];
      void'(mq.pop_front());
      mq.push_back(nb);
    end
  endfunction

  function automatic logic [TB_RND_W-1:0] model_rnd();
    logic [TB_RND_W-1:0] e;
    for (int k = 0; k < TB_RND_W; k++) e[k] = mq[k];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a seed from SEED state, walks the warm-up and lands in RUN
  task automatic load_seed(input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] ch [2];
    ch[0] = hi;
    ch[1] = lo;
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 2)) begin
        seed_valid = 1'b0;
        reseed_req = 1'($urandom);
        tick();
      end
      vectors++;
      if (seed_ready !== 1'b1) begin
        $display("FAIL load_seed_ready: got %b want 1", seed_ready);
        miscompares++;
      end
      seed_valid = 1'b1;
      seed_in    = ch[i];
      reseed_req = 1'b0;
      tick();
    end
    seed_valid = 1'b0;
    model_load({hi, lo});
    vectors++;
    if (seed_zero !== ({hi, lo} == 64'h0)) begin
      $display("FAIL seed_zero_pulse: got %b want %b", seed_zero, ({hi, lo} == 64'h0));
      miscompares++;
    end
    for (int k = 1; k <= TB_WARMUP; k++) begin
      rnd_ready  = 1'($urandom);
      reseed_req = 1'($urandom);
      seed_valid = 1'($urandom);
      seed_in    = $urandom;
      tick();
      vectors++;
      if (rnd_valid !== (k == TB_WARMUP) || seed_zero !== 1'b0) begin
        $display("FAIL warmup_valid: cycle %0d rnd_valid=%b seed_zero=%b want valid=%b zero=0",
                 k, rnd_valid, seed_zero, (k == TB_WARMUP));
        miscompares++;
      end
    end
    reseed_req = 1'b0;
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    model_consume(TB_WARMUP * TB_RND_W);
    vectors++;
    if (rnd !== model_rnd()) begin
      $display("FAIL first_rnd: got %h want %h", rnd, model_rnd());
      miscompares++;
    end
  endtask

  // RUN traffic; ready_mode 0=always, 1=random. Noise on seed_valid is ignored by the DUT.
  task automatic run_cycles(input int n, input bit random_ready);
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (rnd_valid !== 1'b1 || seed_ready !== 1'b0 || rnd !== model_rnd() || seed_zero !== 1'b0) begin
        $display("FAIL run_rnd: cycle %0d rnd=%h valid=%b sready=%b zero=%b want rnd=%h valid=1 sready=0 zero=0",
                 i, rnd, rnd_valid, seed_ready, seed_zero, model_rnd());
        miscompares++;
      end
      rnd_ready  = random_ready ? 1'($urandom) : 1'b1;
      seed_valid = 1'($urandom);
      seed_in    = $urandom;
      tick();
      if (rnd_ready) model_consume(TB_RND_W);
    end
    rnd_ready  = 1'b0;
    seed_valid = 1'b0;
  endtask

  task automatic do_reseed(input bit with_ready);
    reseed_req = 1'b1;
    rnd_ready  = with_ready;
    tick();
    reseed_req = 1'b0;
    rnd_ready  = 1'b0;
    vectors++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b1 || rnd !== model_rnd()) begin
      $display("FAIL reseed: valid=%b sready=%b rnd=%h want valid=0 sready=1 rnd=%h",
               rnd_valid, seed_ready, rnd, model_rnd());
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    vectors++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b1 || rnd !== '0 || seed_zero !== 1'b0) begin
      $display("FAIL reset_in: valid=%b sready=%b rnd=%h zero=%b want 0 1 0 0",
               rnd_valid, seed_ready, rnd, seed_zero);
      miscompares++;
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if (rnd_valid !== 1'b0 || seed_ready !== 1'b1 || rnd !== '0 || seed_zero !== 1'b0) begin
        $display("FAIL reset_idle: cycle %0d valid=%b sready=%b rnd=%h zero=%b want 0 1 0 0",
                 i, rnd_valid, seed_ready, rnd, seed_zero);
        miscompares++;
      end
    end
  endtask

  task automatic test_known_seed();
    load_seed(32'h0, 32'h1);
    run_cycles(25, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      rnd_ready = 1'b0;
      tick();
      vectors++;
      if (rnd !== model_rnd() || rnd_valid !== 1'b1) begin
        $display("FAIL stall_hold: cycle %0d rnd=%h valid=%b want rnd=%h valid=1",
                 i, rnd, rnd_valid, model_rnd());
        miscompares++;
      end
    end
    run_cycles(10, 1'b0);
  endtask

  task automatic test_random_traffic();
    run_cycles(60, 1'b1);
  endtask

  task automatic test_reseed();
    do_reseed(1'b1);
    repeat (3) begin
      tick();
      vectors++;
      if (rnd !== model_rnd() || rnd_valid !== 1'b0) begin
        $display("FAIL reseed_hold: rnd=%h valid=%b want rnd=%h valid=0", rnd, rnd_valid, model_rnd());
        miscompares++;
      end
    end
    load_seed($urandom, $urandom);
    run_cycles(40, 1'b1);
  endtask

  task automatic test_zero_seed();
    do_reseed(1'b0);
    load_seed(32'h0, 32'h0);
    run_cycles(25, 1'b1);
  endtask

  task automatic test_async_reset();
    do_reseed(1'b1);
    seed_valid = 1'b1;
    seed_in    = $urandom;
    tick();
    seed_in    = $urandom;
    tick();
    seed_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b1 || rnd !== '0 || seed_zero !== 1'b0) begin
      $display("FAIL async_reset_warm: valid=%b sready=%b rnd=%h zero=%b want 0 1 0 0",
               rnd_valid, seed_ready, rnd, seed_zero);
      miscompares++;
    end
    #3;
    rst = 1'b0;
    tick();
    vectors++;
    if (rnd_valid !== 1'b0 || seed_ready !== 1'b1 || rnd !== '0) begin
      $display("FAIL async_reset_after: valid=%b sready=%b rnd=%h want 0 1 0", rnd_valid, seed_ready, rnd);
      miscompares++;
    end
    // A half-loaded seed must be discarded by reset
    seed_valid = 1'b1;
    seed_in    = 32'hDEAD_BEEF;
    tick();
    seed_valid = 1'b0;
    #2;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
    load_seed($urandom, $urandom);
    run_cycles(30, 1'b1);
  endtask

  initial begin
    test_reset();
    test_known_seed();
    test_stall();
    test_random_traffic();
    test_reseed();
    test_zero_seed();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
